// File: rtl/cpu_control_fsm.sv
// Multi-cycle instruction sequencer: fetch over a ready-handshaked memory port,
// decode the 4-bit opcode and drive the PC/IR/regfile/ALU/flag strobes.
`timescale 1ns/1ps
module cpu_control_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] opcode,
    input  logic       mem_ready,
    input  logic       carry_flag,
    input  logic       zero_flag,
    output logic       mem_read,
    output logic       mem_write,
    output logic       addr_sel,
    output logic       ir_load,
    output logic       pc_inc,
    output logic       pc_load,
    output logic [2:0] alu_op,
    output logic       reg_write,
    output logic       wb_sel,
    output logic       flag_load,
    output logic       halted
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_CMP, OP_LD,
        OP_ST, OP_JMP, OP_JZ, OP_JNZ, OP_JC, OP_JNC, OP_MOV, OP_HLT
    } op_t;

    localparam logic [2:0] ALU_SUB    = 3'd1;
    localparam logic [2:0] ALU_PASS_B = 3'd7;

    state_t     state;
    state_t     state_next;
    op_t        op;
    logic       is_alu;
    logic       take_jump;
    logic [2:0] alu_sel;

    assign op = op_t'(opcode);

    // Opcode decode shared by EXEC and WB so alu_op stays stable across both.
    always_comb begin
        is_alu    = (opcode >= 4'h1) && (opcode <= 4'h5);
        alu_sel   = 3'd0;
        take_jump = 1'b0;
        if (is_alu) begin
            alu_sel = opcode[2:0] - 3'd1;
        end else if (op == OP_MOV) begin
            alu_sel = ALU_PASS_B;
        end else if (op == OP_CMP) begin
            alu_sel = ALU_SUB;
        end
        case (op)
            OP_JMP:  take_jump = 1'b1;
            OP_JZ:   take_jump = zero_flag;
            OP_JNZ:  take_jump = !zero_flag;
            OP_JC:   take_jump = carry_flag;
            OP_JNC:  take_jump = !carry_flag;
            default: take_jump = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output and state_next gets a default first, so no path
    // through the case statement can leave a variable unassigned (no latches).
    always_comb begin
        state_next = state;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        addr_sel   = 1'b0;
        ir_load    = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        alu_op     = 3'd0;
        reg_write  = 1'b0;
        wb_sel     = 1'b0;
        flag_load  = 1'b0;
        halted     = 1'b0;

        case (state)
            S_FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    // Reset parks the state in FETCH; keep its strobes quiet while held.
                    ir_load    = reset;
                    pc_inc     = reset;
                    state_next = S_DECODE;
                end
            end

            S_DECODE: begin
                case (op)
                    OP_HLT:  state_next = S_HALT;
                    OP_NOP:  state_next = S_FETCH;
                    default: state_next = S_EXEC;
                endcase
            end

            S_EXEC: begin
                alu_op = alu_sel;
                if (is_alu || op == OP_MOV) begin
                    state_next = S_WB;
                end else if (op == OP_CMP) begin
                    flag_load  = 1'b1;
                    state_next = S_FETCH;
                end else if (op == OP_LD || op == OP_ST) begin
                    state_next = S_MEM;
                end else begin
                    pc_load    = take_jump;
                    state_next = S_FETCH;
                end
            end

            S_MEM: begin
                addr_sel = 1'b1;
                if (op == OP_LD) begin
                    mem_read = 1'b1;
                    if (mem_ready) state_next = S_WB;
                end else if (op == OP_ST) begin
                    mem_write = 1'b1;
                    if (mem_ready) state_next = S_FETCH;
                end else begin
                    state_next = S_FETCH;
                end
            end

            S_WB: begin
                reg_write  = 1'b1;
                alu_op     = alu_sel;
                wb_sel     = (op == OP_LD);
                flag_load  = is_alu;
                state_next = S_FETCH;
            end

            S_HALT: begin
                halted = 1'b1;
            end

            default: state_next = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Self-checking bench for cpu_control_fsm: table of per-instruction vectors run
// through a cycle monitor, plus hand-written reset and HALT sequences.
`timescale 1ns/1ps
module tb_cpu_control_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] opcode = 4'h0;
    logic       mem_ready = 1'b0;
    logic       carry_flag = 1'b0;
    logic       zero_flag = 1'b0;
    logic       mem_read, mem_write, addr_sel, ir_load, pc_inc, pc_load;
    logic [2:0] alu_op;
    logic       reg_write, wb_sel, flag_load, halted;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cpu_control_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .carry_flag (carry_flag),
        .zero_flag  (zero_flag),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .addr_sel   (addr_sel),
        .ir_load    (ir_load),
        .pc_inc     (pc_inc),
        .pc_load    (pc_load),
        .alu_op     (alu_op),
        .reg_write  (reg_write),
        .wb_sel     (wb_sel),
        .flag_load  (flag_load),
        .halted     (halted)
    );

    // One instruction: stimulus plus expected per-instruction totals.
    // cyc = 0 means the total cycle count is not compared.
    typedef struct {
        logic [3:0] op;
        logic       c;
        logic       z;
        int         fw;
        int         mw;
        int         cyc;
        int         pc_load;
        int         flag_load;
        int         reg_write;
        logic       wb_sel;
        logic       chk_alu;
        logic [2:0] alu;
        int         mem_wr;
    } vec_t;

    typedef struct {
        int         cyc;
        int         ir_load;
        int         pc_inc;
        int         pc_load;
        int         reg_write;
        int         flag_load;
        int         mem_wr;
        int         both;
        int         halted;
        logic       wb_sel;
        logic [2:0] alu_exec;
        logic [2:0] alu_wb;
        logic       timeout;
    } obs_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic c, input logic z,
                                input int fw, input int mw, input int cyc, input int pcl,
                                input int fl, input int rw, input logic wb,
                                input logic chk, input logic [2:0] alu, input int mwr);
        vec_t v;
        v.op = op; v.c = c; v.z = z; v.fw = fw; v.mw = mw; v.cyc = cyc;
        v.pc_load = pcl; v.flag_load = fl; v.reg_write = rw; v.wb_sel = wb;
        v.chk_alu = chk; v.alu = alu; v.mem_wr = mwr;
        return v;
    endfunction

    // Runs one instruction starting in FETCH (called in the low clock phase),
    // answering memory requests after the requested number of wait cycles.
    task automatic run_instr(input vec_t v, output obs_t o);
        int  fw = 0;
        int  mw = 0;
        int  since_ir = 0;
        bit  seen_ir = 0;
        bit  done = 0;
        o = '{default: 0};
        opcode     = v.op;
        carry_flag = v.c;
        zero_flag  = v.z;
        while (!done) begin
            if (mem_read || mem_write) begin
                if (!addr_sel) begin
                    mem_ready = (fw >= v.fw);
                    if (!mem_ready) fw++;
                end else begin
                    mem_ready = (mw >= v.mw);
                    if (!mem_ready) mw++;
                end
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            #1;
            if (seen_ir && mem_read && !addr_sel) begin
                done = 1;
            end else begin
                o.cyc++;
                if (ir_load)   o.ir_load++;
                if (pc_inc)    o.pc_inc++;
                if (pc_load)   o.pc_load++;
                if (flag_load) o.flag_load++;
                if (mem_write) o.mem_wr++;
                if (halted)    o.halted++;
                if (mem_read && mem_write) o.both++;
                if (reg_write) begin
                    o.reg_write++;
                    o.wb_sel = wb_sel;
                    o.alu_wb = alu_op;
                end
                if (ir_load) begin
                    seen_ir  = 1;
                    since_ir = 0;
                end else if (seen_ir) begin
                    since_ir++;
                end
                if (seen_ir && since_ir == 2) o.alu_exec = alu_op;
                if (o.cyc >= 40) begin
                    o.timeout = 1;
                    done = 1;
                end else begin
                    @(negedge clk);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        obs_t  o;
        vec_t  e;
        string tag;
        int    strobes;
        int    halt_cnt;
        bit [3:0] jtab [5];
        logic [3:0] jops [5];

        // Jump condition table, bit index = {carry, zero}.
        jops = '{4'h9, 4'hA, 4'hB, 4'hC, 4'hD};
        jtab = '{4'b1111, 4'b1010, 4'b0101, 4'b1100, 4'b0011};

        vecs.push_back(mk(4'h0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 3'd0, 0));
        vecs.push_back(mk(4'h1, 0, 0, 0, 0, 4, 0, 1, 1, 0, 1, 3'd0, 0));
        vecs.push_back(mk(4'h2, 0, 0, 1, 0, 5, 0, 1, 1, 0, 1, 3'd1, 0));
        vecs.push_back(mk(4'h3, 0, 0, 0, 0, 4, 0, 1, 1, 0, 1, 3'd2, 0));
        vecs.push_back(mk(4'h4, 0, 0, 0, 0, 4, 0, 1, 1, 0, 1, 3'd3, 0));
        vecs.push_back(mk(4'h5, 0, 0, 2, 0, 6, 0, 1, 1, 0, 1, 3'd4, 0));
        vecs.push_back(mk(4'hE, 0, 0, 0, 0, 4, 0, 0, 1, 0, 1, 3'd7, 0));
        vecs.push_back(mk(4'h7, 0, 0, 0, 0, 5, 0, 0, 1, 1, 0, 3'd0, 0));
        vecs.push_back(mk(4'h7, 0, 0, 2, 2, 9, 0, 0, 1, 1, 0, 3'd0, 0));
        vecs.push_back(mk(4'h8, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3'd0, 2));
        vecs.push_back(mk(4'h6, 0, 0, 0, 0, 3, 0, 1, 0, 0, 1, 3'd1, 0));
        vecs.push_back(mk(4'hA, 0, 1, 0, 0, 3, 1, 0, 0, 0, 0, 3'd0, 0));
        vecs.push_back(mk(4'h6, 0, 0, 0, 0, 3, 0, 1, 0, 0, 1, 3'd1, 0));
        vecs.push_back(mk(4'hA, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 3'd0, 0));
        for (int j = 0; j < 5; j++) begin
            for (int k = 0; k < 4; k++) begin
                vecs.push_back(mk(jops[j], k[1], k[0], 0, 0, 3, int'(jtab[j][k]),
                                  0, 0, 0, 0, 3'd0, 0));
            end
        end

        // Held in reset: FETCH decode with strobes quiet even though mem_ready=1.
        mem_ready = 1'b1;
        opcode    = 4'h8;
        #12;
        check("rst mem_read", mem_read, 1);
        check("rst addr_sel", addr_sel, 0);
        check("rst mem_write", mem_write, 0);
        check("rst halted", halted, 0);
        check("rst ir_load", ir_load, 0);
        check("rst pc_inc", pc_inc, 0);

        // Release, fetch an ST and reset it in the middle of a stalled MEM.
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("st fetch ir_load", ir_load, 1);
        @(negedge clk);
        check("st decode mem_read", mem_read, 0);
        @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        #1;
        check("st mem mem_write", mem_write, 1);
        check("st mem addr_sel", addr_sel, 1);
        #2;
        reset = 1'b0;
        #1;
        check("async rst mem_write", mem_write, 0);
        check("async rst mem_read", mem_read, 1);
        check("async rst addr_sel", addr_sel, 0);
        check("async rst halted", halted, 0);
        mem_ready = 1'b1;
        #1;
        check("async rst ir_load", ir_load, 0);
        @(negedge clk);
        opcode = 4'h0;
        reset  = 1'b1;
        #1;
        check("post rst ir_load", ir_load, 1);
        @(negedge clk);
        check("post rst decode", mem_read, 0);
        @(negedge clk);

        foreach (vecs[i]) begin
            exp_q.push_back(vecs[i]);
            run_instr(vecs[i], o);
            e = exp_q.pop_front();
            tag = $sformatf("v%0d op%0h", i, e.op);
            check({tag, " timeout"}, o.timeout, 0);
            if (e.cyc != 0) check({tag, " cycles"}, o.cyc, e.cyc);
            check({tag, " ir_load"}, o.ir_load, 1);
            check({tag, " pc_inc"}, o.pc_inc, 1);
            check({tag, " pc_load"}, o.pc_load, e.pc_load);
            check({tag, " flag_load"}, o.flag_load, e.flag_load);
            check({tag, " reg_write"}, o.reg_write, e.reg_write);
            check({tag, " mem_write"}, o.mem_wr, e.mem_wr);
            check({tag, " rd_wr_both"}, o.both, 0);
            check({tag, " halted"}, o.halted, 0);
            if (e.reg_write != 0) check({tag, " wb_sel"}, o.wb_sel, e.wb_sel);
            if (e.chk_alu) check({tag, " alu_exec"}, o.alu_exec, e.alu);
            if (e.chk_alu && e.reg_write != 0) check({tag, " alu_wb"}, o.alu_wb, e.alu);
        end

        // HLT: halted from the cycle after DECODE, sticky until reset.
        opcode    = 4'hF;
        mem_ready = 1'b1;
        #1;
        check("hlt fetch ir_load", ir_load, 1);
        @(negedge clk);
        #1;
        check("hlt decode halted", halted, 0);
        @(negedge clk);
        strobes  = 0;
        halt_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            mem_ready = 1'(i % 2);
            #1;
            if (halted) halt_cnt++;
            if (ir_load || pc_inc || pc_load || reg_write || flag_load ||
                mem_read || mem_write) strobes++;
            @(negedge clk);
        end
        check("hlt halted cycles", halt_cnt, 20);
        check("hlt strobes", strobes, 0);
        reset = 1'b0;
        #1;
        check("hlt reset halted", halted, 0);
        @(negedge clk);
        reset = 1'b1;

        exp_q.push_back(mk(4'h0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 3'd0, 0));
        run_instr(exp_q[0], o);
        e = exp_q.pop_front();
        check("after hlt nop cycles", o.cyc, e.cyc);
        check("after hlt nop halted", o.halted, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
